pipe_sel_mux: RTL and testbench
===============================

// Module: pipe_sel_mux
// PURPOSE
//  Registered N:1 operand-select stage for the pipelined datapath: picks one of NUM_IN
//  WIDTH-bit sources by in_sel and registers it behind a valid/ready handshake.
//  Replaces bare 2:1 8-bit selects at stage boundaries; adds an out-of-range select flag
//  and error count. Sits between register-file/forwarding sources and the ALU stage.
// PARAMETERS
//  WIDTH      8                         data width per source
//  NUM_IN     2                         number of sources (>=2)
//  SEL_W      max(1,$clog2(NUM_IN))     in_sel width
//  ERR_CNT_W  8                         width of saturating out-of-range counter
// PORTS
//  clk        in   1               sole clock, rising edge
//  rst_n      in   1               synchronous, active-low reset
//  in_data    in   NUM_IN*WIDTH    packed sources; source k = in_data[k*WIDTH +: WIDTH]
//  in_sel     in   SEL_W           source index, sampled with the beat
//  in_valid   in   1               upstream beat valid
//  in_ready   out  1               stage can accept a beat this cycle
//  out_data   out  WIDTH           selected, registered data
//  out_sel    out  SEL_W           in_sel that produced out_data
//  out_err    out  1               beat had in_sel >= NUM_IN
//  out_valid  out  1               downstream beat valid
//  out_ready  in   1               downstream accepts
//  err_cnt    out  ERR_CNT_W       count of accepted out-of-range beats, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_sel=0, out_err=0, err_cnt=0,
//    held beats dropped; in_ready=0 while rst_n=0. Reset mid-transfer discards data.
//  - Accept = in_valid & in_ready; emit = out_valid & out_ready.
//  - Select: in_sel<NUM_IN -> source in_sel, err=0; else data=0, err=1. No X-propagation.
//  - Latency 1 clk from accept to out_valid; order preserved; one beat/clk when unstalled.
//  - out_data/out_sel/out_err stable while out_valid & !out_ready (AXI-style hold).
//  - in_valid may drop without accept; in_data/in_sel only sampled on accept.
//  - err_cnt += 1 on each accepted err beat; holds at 2^ERR_CNT_W-1.
//  - Default (single slot): in_ready = !out_valid | out_ready (combinational from out_ready).
//    Accept & emit same cycle -> out regs reload, out_valid stays 1.
//    Emit without accept -> out_valid<=0. Accept without emit (only when empty) -> out_valid<=1.
// CONFIGURATION
//  PIPE_SEL_MUX_SKID_EN defined: two-slot skid buffer; in_ready is a flop (no comb path
//  out_ready->in_ready). FSM over held beats:
//    EMPTY: accept -> ONE.
//    ONE:   accept&!emit -> FULL (beat into skid); emit&!accept -> EMPTY;
//           accept&emit -> ONE (out reloads from input).
//    FULL:  in_ready=0; emit -> ONE (out reloads from skid).
//    in_ready = (state!=FULL), registered. Latency still 1 clk; full throughput.
//  Not defined: single-slot behaviour above; no skid registers synthesised.
// STRUCTURE
//  - pipe_sel_mux_pkg: state typedef {EMPTY,ONE,FULL}, sel_w(n) function,
//    beat struct {data,sel,err}.
//  - Sub-module pipe_sel_mux_slot: one beat register with load enable and reset; instantiated
//    once (out) or twice (out + skid) under PIPE_SEL_MUX_SKID_EN.
//  - Select/err decode is combinational in top; counter in top.
// TESTING (run both with and without PIPE_SEL_MUX_SKID_EN; WIDTH=8, NUM_IN=3, SEL_W=2)
//  - Reset: rst_n=0 2 clks -> out_valid=0, out_data=0, err_cnt=0; in_ready=0 during reset.
//  - Select: sources {0x11,0x22,0x33}, sel=2, out_ready=1 -> next clk out_data=0x33,
//    out_sel=2, out_err=0.
//  - Out-of-range: sel=3 accepted -> out_data=0x00, out_err=1, err_cnt=1; 300 such beats
//    with ERR_CNT_W=8 -> err_cnt=255.
//  - Backpressure: stream 0xA0..0xA7, out_ready low 3 clks mid-stream -> data held stable,
//    in_ready=0 (after 1 beat default, 2 beats SKID), all 8 delivered in order, none duplicated.
//  - Throughput: in_valid=out_ready=1 for 16 clks -> 16 beats out, out_valid continuous
//    from clk 1.
//  - Reset mid-stall: out_valid=1, out_ready=0, rst_n=0 1 clk -> out_valid=0, err_cnt=0,
//    held beats never emitted.

Source files
------------

// File: rtl/pipe_sel_mux_pkg.sv
// Shared types for the registered operand-select stage: held-beat state,
// select-width helper and the beat record at the default 8-bit/2-source size.
package pipe_sel_mux_pkg;

  // Number of beats held by the stage (skid build); single-slot uses EMPTY/ONE only.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Select width for n sources, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_IN = 2;

  // Beat at the default configuration; the top builds the same layout at its own widths.
  typedef struct packed {
    logic [DEF_WIDTH-1:0]           data;
    logic [sel_w(DEF_NUM_IN)-1:0]   sel;
    logic                           err;
  } beat_t;

endpackage

// File: rtl/pipe_sel_mux_slot.sv
// One beat register with load enable; cleared by synchronous active-low reset.
module pipe_sel_mux_slot
  import pipe_sel_mux_pkg::*;
#(
  parameter type BEAT_T = beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ld,
  input  BEAT_T d,
  output BEAT_T q
);

  // Hold the beat until the owner loads a new one.
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/pipe_sel_mux.sv
// Registered N:1 operand select behind a valid/ready handshake.
// Out-of-range selects produce zero data, an err flag and bump a saturating counter.
// Build option: PIPE_SEL_MUX_SKID_EN adds a second (skid) slot so in_ready is a flop
// with no combinational path from out_ready; otherwise a single slot is used.
module pipe_sel_mux
  import pipe_sel_mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 2,
  parameter int SEL_W     = sel_w(NUM_IN),
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_w_t;

  logic [NUM_IN-1:0][WIDTH-1:0] src;
  beat_w_t in_beat, out_d, out_q;
  logic    accept, emit, out_ld;

  assign src    = in_data;
  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Decode select by equality match so an out-of-range index never reads X.
  always_comb begin
    in_beat.data = '0;
    in_beat.sel  = in_sel;
    in_beat.err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        in_beat.data = src[k];
        in_beat.err  = 1'b0;
      end
    end
  end

`ifdef PIPE_SEL_MUX_SKID_EN
  state_t  state, state_nxt;
  logic    in_ready_q, skid_ld;
  beat_w_t skid_q;

  // in_ready_q idles high through reset so the first post-reset cycle can accept;
  // gating with rst_n keeps in_ready low while reset is asserted.
  assign in_ready  = in_ready_q & rst_n;
  assign out_valid = (state != EMPTY);

  // Output reloads when empty, on a pass-through, or from the skid when draining FULL.
  assign out_ld  = (accept & (~out_valid | emit)) | ((state == FULL) & emit);
  assign skid_ld = accept & out_valid & ~emit;
  assign out_d   = (state == FULL) ? skid_q : in_beat;

  // Track how many beats are held.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !emit)      state_nxt = FULL;
        else if (emit && !accept) state_nxt = EMPTY;
      end
      FULL:    if (emit) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // State and registered ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  pipe_sel_mux_slot #(.BEAT_T(beat_w_t)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (skid_ld),
    .d     (in_beat),
    .q     (skid_q)
  );
`else
  logic out_valid_q;

  // Ready whenever the slot is empty or draining this cycle.
  assign in_ready  = rst_n & (~out_valid_q | out_ready);
  assign out_valid = out_valid_q;
  assign out_ld    = accept;
  assign out_d     = in_beat;

  // Valid sets on accept, clears on emit without a refill.
  always_ff @(posedge clk) begin
    if (!rst_n)      out_valid_q <= 1'b0;
    else if (accept) out_valid_q <= 1'b1;
    else if (emit)   out_valid_q <= 1'b0;
  end
`endif

  pipe_sel_mux_slot #(.BEAT_T(beat_w_t)) u_out (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (out_ld),
    .d     (out_d),
    .q     (out_q)
  );

  assign out_data = out_q.data;
  assign out_sel  = out_q.sel;
  assign out_err  = out_q.err;

  // Count accepted out-of-range beats, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (accept && in_beat.err && (err_cnt != {ERR_CNT_W{1'b1}}))
      err_cnt <= err_cnt + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench for pipe_sel_mux (WIDTH=8, NUM_IN=3, SEL_W=2); expectations
// adapt to PIPE_SEL_MUX_SKID_EN.
module tb_pipe_sel_mux;
  localparam int WIDTH = 8, NUM_IN = 3, SEL_W = 2, ERR_CNT_W = 8;
`ifdef PIPE_SEL_MUX_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid, in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err, out_valid, out_ready;
  logic [ERR_CNT_W-1:0]    err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_sel_mux #(
    .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int         rx, tx;
    logic       acc;
    logic [7:0] b;

    // reset with upstream pushing
    rst_n = 1'b0; in_valid = 1'b1; in_sel = '0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_sel",   out_sel,   0);
    chk("rst_err",   out_err,   0);
    chk("rst_cnt",   err_cnt,   0);
    chk("rst_ready", in_ready,  0);

    // in-range selects
    rst_n = 1'b1; in_data = {8'h33, 8'h22, 8'h11}; in_sel = 2'd2;
    settle();
    chk("sel_ready", in_ready, 1);
    tick();
    chk("sel2_valid", out_valid, 1);
    chk("sel2_data",  out_data,  8'h33);
    chk("sel2_sel",   out_sel,   2);
    chk("sel2_err",   out_err,   0);
    in_sel = 2'd0; tick();
    chk("sel0_data", out_data, 8'h11);
    in_sel = 2'd1; tick();
    chk("sel1_data", out_data, 8'h22);

    // out-of-range select and counter saturation
    in_sel = 2'd3; tick();
    chk("oor_data", out_data, 8'h00);
    chk("oor_err",  out_err,  1);
    chk("oor_sel",  out_sel,  3);
    chk("oor_cnt1", err_cnt,  1);
    for (int i = 2; i <= 300; i++) begin
      tick();
      if (i == 200) chk("oor_cnt200", err_cnt, 200);
    end
    chk("oor_cnt_sat", err_cnt, 255);
    in_valid = 1'b0; tick();
    chk("oor_drain", out_valid, 0);

    // backpressure: out_ready low for cycles 3..5
    rx = 0; tx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      b         = 8'hA0 + 8'(tx);
      in_valid  = (tx < 8);
      in_sel    = 2'd0;
      in_data   = {8'h00, 8'h00, b};
      out_ready = !(cyc >= 3 && cyc <= 5);
      settle();
      if (cyc == 3)              chk("bp_ready3", in_ready, {31'd0, SKID});
      if (cyc == 4 || cyc == 5)  chk("bp_ready_stall", in_ready, 0);
      if (out_valid && !out_ready) chk("bp_hold", out_data, 8'hA0 + rx);
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, 8'hA0 + rx);
        rx++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) tx++;
    end
    chk("bp_sent", tx, 8);
    chk("bp_recv", rx, 8);

    // full throughput
    in_sel = 2'd1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b        = 8'h40 + 8'(i);
      in_valid = 1'b1;
      in_data  = {8'h00, b, 8'h00};
      settle();
      chk("tp_ready", in_ready, 1);
      tick();
      chk("tp_valid", out_valid, 1);
      chk("tp_data",  out_data,  8'h40 + i);
    end
    in_valid = 1'b0; settle(); tick();
    chk("tp_drain", out_valid, 0);

    // reset while stalled with held beats
    in_sel = 2'd3; in_data = {8'h55, 8'h66, 8'h77}; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    if (SKID) tick();
    in_valid = 1'b0; settle();
    chk("ms_pre_valid", out_valid, 1);
    rst_n = 1'b0; tick();
    chk("ms_valid", out_valid, 0);
    chk("ms_cnt",   err_cnt,   0);
    chk("ms_err",   out_err,   0);
    chk("ms_data",  out_data,  0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_no_emit", out_valid, 0);
    end
    chk("ms_cnt_after", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
